// File: rtl/shift_reg.sv
// ============================================================================
// Module   : shift_reg
// Brief    : WIDTH-bit, DEPTH-stage enabled delay line with async active-low reset
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Stage 0 captures the input word; every later stage takes its predecessor.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_stage[0] <= '0;
          end else if (en) begin
            r_stage[0] <= d;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_stage[i] <= '0;
          end else if (en) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end
    end
  endgenerate

  assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_shift_reg.sv
// ============================================================================
// Module   : tb_shift_reg
// Brief    : Directed vector bench for shift_reg at (4,4), (4,1) and (8,7)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b, en_c;
  logic [3:0] d_a, d_b, q_a, q_b;
  logic [7:0] d_c, q_c;

  int errors = 0;
  int checks = 0;

  always #1 clk = ~clk;

  shift_reg #(.WIDTH(4), .DEPTH(4)) u_dut_a (.clk(clk), .rst(rst), .en(en_a), .d(d_a), .q(q_a));
  shift_reg #(.WIDTH(4), .DEPTH(1)) u_dut_b (.clk(clk), .rst(rst), .en(en_b), .d(d_b), .q(q_b));
  shift_reg #(.WIDTH(8), .DEPTH(7)) u_dut_c (.clk(clk), .rst(rst), .en(en_c), .d(d_c), .q(q_c));

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] d;
    logic [3:0] q;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] dv, input logic [3:0] qv);
    vec_t v;
    v.rst = r;
    v.en  = e;
    v.d   = dv;
    v.q   = qv;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge, then settle half a unit so sampling is clear of the edge.
  task automatic tick();
    @(posedge clk);
    #0.5;
  endtask

  initial begin
    rst  = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    d_a  = 4'h0; d_b  = 4'h0; d_c  = 8'h00;
    #0.2;
    check("reset_initial", {4'h0, q_a}, 8'h00);

    // Reset held, en ignored
    vt.push_back(mk(1'b0, 1'b0, 4'h8, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 4'h8, 4'h0));
    // Hold from empty
    vt.push_back(mk(1'b1, 1'b0, 4'h8, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 4'h8, 4'h0));
    // Fill with 1000
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h0));
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h0));
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h0));
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h8));
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h8));
    // Ordering 1..5
    vt.push_back(mk(1'b1, 1'b1, 4'h1, 4'h8));
    vt.push_back(mk(1'b1, 1'b1, 4'h2, 4'h8));
    vt.push_back(mk(1'b1, 1'b1, 4'h3, 4'h8));
    vt.push_back(mk(1'b1, 1'b1, 4'h4, 4'h1));
    vt.push_back(mk(1'b1, 1'b1, 4'h5, 4'h2));
    // Stall three cycles with changing d, which must not be captured
    vt.push_back(mk(1'b1, 1'b0, 4'h9, 4'h2));
    vt.push_back(mk(1'b1, 1'b0, 4'hA, 4'h2));
    vt.push_back(mk(1'b1, 1'b0, 4'hB, 4'h2));
    // Resume: no gap, no repeat
    vt.push_back(mk(1'b1, 1'b1, 4'h6, 4'h3));
    vt.push_back(mk(1'b1, 1'b1, 4'h7, 4'h4));
    vt.push_back(mk(1'b1, 1'b1, 4'h8, 4'h5));
    vt.push_back(mk(1'b1, 1'b1, 4'h9, 4'h6));

    for (int i = 0; i < vt.size(); i++) begin
      rst  = vt[i].rst;
      en_a = vt[i].en;
      d_a  = vt[i].d;
      tick();
      check($sformatf("vec%0d", i), {4'h0, q_a}, {4'h0, vt[i].q});
    end

    // Mid-run async reset pulse between edges; pipeline holds 9,8,7,6
    rst = 1'b0;
    #0.2;
    check("async_clear", {4'h0, q_a}, 8'h00);
    #0.2;
    rst = 1'b1;
    #0.2;
    check("after_release", {4'h0, q_a}, 8'h00);
    en_a = 1'b1;
    d_a  = 4'hC; tick(); check("refill1", {4'h0, q_a}, 8'h00);
    d_a  = 4'hD; tick(); check("refill2", {4'h0, q_a}, 8'h00);
    d_a  = 4'hE; tick(); check("refill3", {4'h0, q_a}, 8'h00);
    d_a  = 4'hF; tick(); check("refill4", {4'h0, q_a}, 8'h0C);
    en_a = 1'b0;

    // DEPTH=1: plain enabled register
    check("d1_reset_state", {4'h0, q_b}, 8'h00);
    en_b = 1'b1; d_b = 4'h5; tick(); check("d1_load5", {4'h0, q_b}, 8'h05);
    en_b = 1'b0; d_b = 4'h7; tick(); check("d1_hold", {4'h0, q_b}, 8'h05);
    en_b = 1'b1; d_b = 4'hA; tick(); check("d1_loadA", {4'h0, q_b}, 8'h0A);
    en_b = 1'b0;

    // WIDTH=8, DEPTH=7: latency 7 with a disabled edge that must not count
    begin
      logic [7:0] words [10];
      logic [7:0] expq  [10];
      words = '{8'hA5, 8'h3C, 8'hFF, 8'h81, 8'h12, 8'h7E, 8'hC3, 8'h00, 8'h00, 8'h00};
      expq  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C, 8'hFF, 8'h81};
      for (int i = 0; i < 10; i++) begin
        if (i == 3) begin
          en_c = 1'b0; d_c = 8'h55;
          tick();
          check("w8_stall", q_c, 8'h00);
        end
        en_c = 1'b1;
        d_c  = words[i];
        tick();
        check($sformatf("w8_edge%0d", i + 1), q_c, expq[i]);
      end
      en_c = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
